pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised bit-level pipeline register chain. It replaces single-bit D flip-flop staging with a WIDTH-bit, DEPTH-stage register pipeline that carries per-stage valid bits, valid/ready backpressure with bubble collapsing, flush, and synchronous preset. It sits between datapath slices of the bit-level pipelined arithmetic units, where stall-tolerant retiming is needed.

## Interface
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages (>=1)
- RST_VAL, {WIDTH{1'b0}}, stage data value after rst
- SET_VAL, {WIDTH{1'b1}}, stage data value loaded by set
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous, active-high; highest priority
- set  in  1  synchronous preset: fill every stage with SET_VAL tokens
- flush  in  1  synchronous: invalidate all stages
- in_valid  in  1  upstream token present
- in_ready  out  1  chain accepts in_data this cycle
- in_data  in  WIDTH  upstream data
- out_valid  out  1  token present at last stage
- out_ready  in  1  downstream accepts token
- out_data  out  WIDTH  last-stage data
- count  out  $clog2(DEPTH+1)  number of valid stages

## Operation
- Per stage i (0..DEPTH-1): data[i] (WIDTH) and valid[i] registers.
- Control priority on a clock edge: rst > flush > set > normal.
- rst: all data[i]=RST_VAL, valid[i]=0.
- flush: valid[i]=0; data unchanged.
- set: data[i]=SET_VAL, valid[i]=1 for all i (DEPTH tokens queued).
- While any of rst/flush/set is high: in_ready=0 and out_valid=0. No transfer occurs on either side that cycle.
- Normal operation uses a ready chain: adv[DEPTH]=out_ready; adv[i]=~valid[i] | adv[i+1]; in_ready=adv[0].
- Stage i loads from stage i-1 (stage 0 from in_data/in_valid) when adv[i]=1. Otherwise it holds.
- On load, valid[i] takes the predecessor's valid. A bubble therefore propagates, and a stalled tail lets upstream tokens close gaps (bubble collapsing).
- out_valid=valid[DEPTH-1]; out_data=data[DEPTH-1]. Both are registered outputs, with no combinational path from in_data.
- in_ready depends combinationally on out_ready and valid bits. No other combinational input-to-output path exists.
- count=popcount(valid). It is registered, updated each edge, and exact after rst/flush (0) and after set (DEPTH).
- Ordering: tokens leave in arrival order. No token is lost or duplicated under any in_valid/out_ready pattern.
- Data of an invalid stage is don't-care to the consumer. Data of a stage only changes when that stage loads.

## Timing
- Reset values: out_valid=0, out_data=RST_VAL, count=0. in_ready=0 during rst, and 1 in the first cycle after rst.
- Latency: a token accepted at edge t into an empty chain with out_ready=1 is presented on out_data after edge t+DEPTH-1. It transfers at edge t+DEPTH.
- Throughput: 1 token/cycle when out_ready is held high.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1: in_ready=1, and simultaneous accept plus emit keeps count=DEPTH.
- Simultaneous in_valid and flush: the input is not accepted, and count=0 next cycle.
- Reset mid-stream: any in-flight tokens are discarded, with count=0 the next cycle.
- set followed by out_ready=1 with no input: exactly DEPTH SET_VAL tokens emerge on DEPTH consecutive cycles, then out_valid=0.

## Structure
- Shared package pipe_pkg holds the count-width helper function (clog2 of DEPTH+1) and the default RST_VAL/SET_VAL constants.
- One sub-module, pipe_stage: a WIDTH-bit data register plus valid bit. It has inputs clk, rst, flush, set, ld, d, v_in and outputs q, v_out, with the same priority rules.
- The top module instantiates DEPTH pipe_stage instances via generate, and contains the adv chain and the count register.

## Test plan
- WIDTH=8, DEPTH=4, out_ready=1: drive 0x01..0x0A one per cycle -> outputs 0x01..0x0A in order, first output valid 3 cycles after first accept, count steady at 4.
- Fill, then stall: out_ready=0 with continuous input -> after 4 accepts in_ready=0 and count=4. Raise out_ready -> tokens drain in order with no loss.
- Bubble collapse: send 0xAA, skip 2 cycles, send 0xBB, all with out_ready=0 -> after 0xBB is accepted, count=2 and both tokens are adjacent in the last two stages. Release -> 0xAA then 0xBB on consecutive cycles.
- Preset: pulse set for one cycle with out_ready=1 -> 4 consecutive outputs of 0xFF, count 4,3,2,1,0.
- Flush and reset mid-stream: with 3 tokens in flight, pulse flush together with in_valid=1 -> count=0, out_valid=0, input not accepted. Repeat with rst -> out_data=0x00, count=0.
- Random in_valid/out_ready (10k cycles) against a scoreboard FIFO model -> exact ordering and count match every cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_pkg;

  // Per-bit fill values replicated to WIDTH for the default reset/preset data.
  localparam logic DEF_RST_BIT = 1'b0;
  localparam logic DEF_SET_BIT = 1'b1;

  // Width needed to hold a stage count of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready bus for the pipeline chain: upstream (in_*) and downstream (out_*) sides.
interface pipe_reg_chain_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: produces input tokens and consumes output tokens.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Chain side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module pipe_stage #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             set,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             v_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  // Next state: flush > set > load > hold; flush leaves data untouched.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (set) begin
      data_d  = SET_VAL;
      valid_d = 1'b1;
    end else if (ld) begin
      data_d  = d;
      valid_d = v_in;
    end
  end

  // Stage registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign v_out = valid_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, flush and preset.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEF_SET_BIT}},
  localparam int unsigned     CNT_W   = cnt_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set,
  input  logic               flush,
  pipe_reg_chain_if.slave    bus,
  output logic [CNT_W-1:0]   count
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] d_c    [DEPTH];
  logic [DEPTH-1:0] v_c;
  logic [DEPTH-1:0] adv_c;
  logic             ctrl_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             emit_c;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign ctrl_c = rst | flush | set;

  // Ready chain: a stage may advance when it or any stage after it is empty,
  // or when the consumer takes the head token. Unrolled as a suffix-AND so
  // there is no feedback through a single vector.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    adv_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      all_v    = all_v & valid_q[i];
      adv_c[i] = bus.out_ready | ~all_v;
    end
  end

  // Stage inputs: stage 0 from the upstream bus, others from their predecessor.
  always_comb begin
    d_c[0] = bus.in_data;
    v_c    = '0;
    v_c[0] = bus.in_valid;
    for (int i = 1; i < int'(DEPTH); i++) begin
      d_c[i] = data_q[i-1];
      v_c[i] = valid_q[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL),
      .SET_VAL (SET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .set   (set),
      .ld    (adv_c[g]),
      .d     (d_c[g]),
      .v_in  (v_c[g]),
      .q     (data_q[g]),
      .v_out (valid_q[g])
    );
  end

  // No handshake completes on either side while a control pulse is active.
  assign in_ready_c    = adv_c[0] & ~ctrl_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q[DEPTH-1] & ~ctrl_c;
  assign bus.out_data  = data_q[DEPTH-1];

  assign accept_c = bus.in_valid & in_ready_c;
  assign emit_c   = valid_q[DEPTH-1] & bus.out_ready;

  // Occupancy tracked incrementally; equals popcount of the valid bits.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (set) begin
      count_d = CNT_W'(DEPTH);
    end else begin
      count_d = count_q + CNT_W'(accept_c) - CNT_W'(emit_c);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: vector table, directed corner cases, random scoreboard run.
module tb_pipe_reg_chain;
  import pipe_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = cnt_w(D);

  logic          clk;
  logic          rst;
  logic          set;
  logic          flush;
  logic [CW-1:0] count;

  pipe_reg_chain_if #(.WIDTH(W)) bus ();

  pipe_reg_chain #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (8'h00),
    .SET_VAL (8'hFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .set   (set),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  int checks   = 0;
  int failures = 0;
  bit sb_en    = 1'b0;
  logic [W-1:0] sb_q [$];

  typedef struct {
    logic         iv;
    logic         ordy;
    logic [W-1:0] din;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic         exp_ird;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vec [15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic [W-1:0] din);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.in_data   = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: checks occupancy each cycle, order/content of every emitted token.
  always @(negedge clk) begin
    if (sb_en) begin
      chk("sb_count", 32'(count), 32'(sb_q.size()));
      if (rst || flush) begin
        sb_q.delete();
      end else if (set) begin
        sb_q.delete();
        for (int i = 0; i < int'(D); i++) sb_q.push_back(8'hFF);
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_emit: got token %0h expected no token at %0t", bus.out_data, $time);
          end else begin
            logic [W-1:0] exp_d;
            exp_d = sb_q.pop_front();
            if (bus.out_data !== exp_d) begin
              failures++;
              $display("FAIL sb_data: got %0h expected %0h at %0t", bus.out_data, exp_d, $time);
            end
          end
        end
        if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Streaming vectors: 0x01..0x0A with out_ready held high, then drain.
    vec[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 3'd0};
    vec[1]  = '{1'b1, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 3'd1};
    vec[2]  = '{1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 3'd2};
    vec[3]  = '{1'b1, 1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 3'd3};
    vec[4]  = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h01, 1'b1, 3'd4};
    vec[5]  = '{1'b1, 1'b1, 8'h06, 1'b1, 8'h02, 1'b1, 3'd4};
    vec[6]  = '{1'b1, 1'b1, 8'h07, 1'b1, 8'h03, 1'b1, 3'd4};
    vec[7]  = '{1'b1, 1'b1, 8'h08, 1'b1, 8'h04, 1'b1, 3'd4};
    vec[8]  = '{1'b1, 1'b1, 8'h09, 1'b1, 8'h05, 1'b1, 3'd4};
    vec[9]  = '{1'b1, 1'b1, 8'h0A, 1'b1, 8'h06, 1'b1, 3'd4};
    vec[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h07, 1'b1, 3'd4};
    vec[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h08, 1'b1, 3'd3};
    vec[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h09, 1'b1, 3'd2};
    vec[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h0A, 1'b1, 3'd1};
    vec[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 3'd0};

    // Reset.
    rst = 1'b1; set = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    rst = 1'b0;
    sb_en = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_out_data", 32'(bus.out_data), 32'h00);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Table-driven streaming run.
    for (int k = 0; k < 15; k++) begin
      drive(vec[k].iv, vec[k].ordy, vec[k].din);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vec[k].exp_ov));
      if (vec[k].exp_ov) chk($sformatf("vec%0d_out_data", k), 32'(bus.out_data), 32'(vec[k].exp_od));
      chk($sformatf("vec%0d_in_ready", k), 32'(bus.in_ready), 32'(vec[k].exp_ird));
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(vec[k].exp_cnt));
      step();
    end

    // Fill then stall: only DEPTH tokens are accepted.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + k));
      @(negedge clk);
      chk($sformatf("fill%0d_in_ready", k), 32'(bus.in_ready), (k < int'(D)) ? 32'd1 : 32'd0);
      step();
    end
    @(negedge clk);
    chk("full_count", 32'(count), 32'(D));
    chk("full_head", 32'(bus.out_data), 32'h10);
    drive(1'b0, 1'b1, 8'h00);
    repeat (D + 2) step();
    @(negedge clk);
    chk("drained_count", 32'(count), 32'd0);

    // Bubble collapse with the consumer stalled.
    drive(1'b1, 1'b0, 8'hAA); step();
    drive(1'b0, 1'b0, 8'h00); step();
    step();
    drive(1'b1, 1'b0, 8'hBB); step();
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("bubble_count", 32'(count), 32'd2);
    step();
    step();
    drive(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    chk("bubble_head_valid", 32'(bus.out_valid), 32'd1);
    chk("bubble_head_data", 32'(bus.out_data), 32'hAA);
    step();
    @(negedge clk);
    chk("bubble_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bubble_second_data", 32'(bus.out_data), 32'hBB);
    step();
    @(negedge clk);
    chk("bubble_done_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Preset: DEPTH 0xFF tokens drain on consecutive cycles.
    set = 1'b1;
    drive(1'b1, 1'b1, 8'h33);
    @(negedge clk);
    chk("set_in_ready", 32'(bus.in_ready), 32'd0);
    chk("set_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    set = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    for (int j = 0; j <= int'(D); j++) begin
      @(negedge clk);
      chk($sformatf("preset%0d_count", j), 32'(count), 32'(int'(D) - j));
      chk($sformatf("preset%0d_valid", j), 32'(bus.out_valid), (j < int'(D)) ? 32'd1 : 32'd0);
      if (j < int'(D)) chk($sformatf("preset%0d_data", j), 32'(bus.out_data), 32'hFF);
      step();
    end

    // Flush with three tokens in flight and a competing input.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'(8'h41 + k));
      step();
    end
    flush = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    @(negedge clk);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_after_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'(8'h61 + k));
      step();
    end
    drive(1'b0, 1'b0, 8'h00);
    step();
    @(negedge clk);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_data", 32'(bus.out_data), 32'h61);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h77);
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'h00);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Random handshake traffic against the scoreboard, with rare flushes.
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      flush = ($urandom_range(0, 299) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 1'b1, 8'h00);
    repeat (D + 2) step();
    @(negedge clk);
    chk("final_count", 32'(count), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
